// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: removes full rows from the playfield, compacts the rest downward and zero-fills the top.
// Optional LINE_CLEAR_MASK_EN adds cleared_mask_o, a per-row record of which rows were cleared.
module line_clear_ctrl #(
    parameter int width_p  = 10,
    parameter int height_p = 20,
    parameter int depth_p  = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  start_v_i,
    output logic                                  ready_o,
    output logic                                  busy_o,
    input  logic [height_p*width_p*depth_p-1:0]   matrix_i,
    output logic [$clog2(height_p)-1:0]           set_row_addr_o,
    output logic [width_p*depth_p-1:0]            set_row_data_o,
    output logic                                  set_v_o,
    output logic                                  done_v_o,
`ifdef LINE_CLEAR_MASK_EN
    output logic [$clog2(height_p+1)-1:0]         lines_cleared_o,
    output logic [height_p-1:0]                   cleared_mask_o
`else
    output logic [$clog2(height_p+1)-1:0]         lines_cleared_o
`endif
);
    localparam int rw_lp = width_p * depth_p;
    localparam int aw_lp = $clog2(height_p);
    localparam int cw_lp = $clog2(height_p + 1);

    typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_e;

    state_e             state_q, state_d;
    logic [cw_lp-1:0]   rd_q, rd_d, wr_q, wr_d, cnt_q, cnt_d, lines_q, lines_d;
    logic [rw_lp-1:0]   row_rd;
    logic               row_full;

    always_comb begin
        row_rd = '0;
        for (int r = 0; r < height_p; r++)
            if (rd_q == cw_lp'(r)) row_rd = matrix_i[r*rw_lp +: rw_lp];
        row_full = 1'b1;
        for (int c = 0; c < width_p; c++)
            if (row_rd[c*depth_p +: depth_p] == '0) row_full = 1'b0;
    end

    always_comb begin
        state_d        = state_q;
        rd_d           = rd_q;
        wr_d           = wr_q;
        cnt_d          = cnt_q;
        lines_d        = lines_q;
        set_v_o        = 1'b0;
        set_row_addr_o = '0;
        set_row_data_o = '0;
        case (state_q)
            IDLE: if (start_v_i) begin
                state_d = SCAN;
                rd_d    = cw_lp'(height_p - 1);
                wr_d    = cw_lp'(height_p - 1);
                cnt_d   = '0;
            end
            SCAN: begin
                rd_d = rd_q - 1'b1;
                if (row_full) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    wr_d = wr_q - 1'b1;
                    // a row that has not moved yet needs no rewrite
                    if (rd_q != wr_q) begin
                        set_v_o        = 1'b1;
                        set_row_addr_o = wr_q[aw_lp-1:0];
                        set_row_data_o = row_rd;
                    end
                end
                if (rd_q == '0) state_d = (cnt_d != '0) ? FILL : DONE;
            end
            FILL: begin
                set_v_o        = 1'b1;
                set_row_addr_o = wr_q[aw_lp-1:0];
                wr_d           = wr_q - 1'b1;
                if (wr_q == '0) state_d = DONE;
            end
            DONE: begin
                lines_d = cnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
        end
    end

    assign ready_o         = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign done_v_o        = (state_q == DONE);
    assign lines_cleared_o = lines_q;

`ifdef LINE_CLEAR_MASK_EN
    logic [height_p-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (state_q == IDLE && start_v_i) mask_d = '0;
        else if (state_q == SCAN && row_full) mask_d[rd_q[aw_lp-1:0]] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) mask_q <= '0;
        else            mask_q <= mask_d;
    end

    assign cleared_mask_o = mask_q;
`endif
endmodule
